// File: rtl/mem_arbiter.sv
// Memory port arbiter: DMA over 6502 core, with a burst limiter that yields one slot to a waiting core.
// Define MEM_ARB_STATS_EN to add the saturating cpu_stall_cnt output.
module mem_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int DMA_MAX_BURST = 4
) (
    input  logic              ph1,
    input  logic              reset_b,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_rdy,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       cpu_stall_cnt
`endif
);

    // state   | meaning
    // S_CPU   | last beat was CPU or bus idle
    // S_DMA   | DMA burst in progress, burst_cnt counts beats the core waited through
    // S_YIELD | one cycle with DMA blocked so a waiting core gets a beat
    typedef enum logic [1:0] {S_CPU, S_DMA, S_YIELD} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_DMA} tag_t;

    localparam logic [3:0] MAX_BURST = 4'(DMA_MAX_BURST);

    state_t     state, state_nxt;
    tag_t       tag, tag_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    logic       force_cpu, grant_dma, grant_cpu;

    // Grants are gated by reset so the bus stays quiet while reset_b is low.
    always_comb begin
        force_cpu = (state == S_YIELD);
        grant_dma = reset_b & dma_req & ~force_cpu;
        grant_cpu = reset_b & cpu_req & ~grant_dma;
        cpu_rdy   = reset_b & ~(cpu_req & ~grant_cpu);
        dma_gnt   = grant_dma;
        mem_en    = grant_cpu | grant_dma;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_dma) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (grant_cpu) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        case (state)
            S_CPU: begin
                if (grant_dma) begin
                    state_nxt = S_DMA;
                    burst_nxt = 4'd1;
                    if (cpu_req && (4'd1 >= MAX_BURST)) state_nxt = S_YIELD;
                end
            end
            S_DMA: begin
                if (!grant_dma) begin
                    state_nxt = S_CPU;
                    burst_nxt = 4'd0;
                end else if (cpu_req) begin
                    burst_nxt = burst_cnt + 4'd1;
                    if (burst_nxt >= MAX_BURST) state_nxt = S_YIELD;
                end else begin
                    // an idle core never accumulates toward a yield
                    burst_nxt = 4'd0;
                end
            end
            S_YIELD: begin
                state_nxt = S_CPU;
                burst_nxt = 4'd0;
            end
            default: begin
                state_nxt = S_CPU;
                burst_nxt = 4'd0;
            end
        endcase
    end

    always_comb begin
        tag_nxt = TAG_NONE;
        if (grant_dma && !dma_we)      tag_nxt = TAG_DMA;
        else if (grant_cpu && !cpu_we) tag_nxt = TAG_CPU;
    end

    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            state     <= S_CPU;
            burst_cnt <= 4'd0;
            tag       <= TAG_NONE;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            tag       <= tag_nxt;
        end
    end

    assign dma_rvalid = (tag == TAG_DMA);
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            cpu_stall_cnt <= 16'd0;
        end else if (!cpu_rdy && (cpu_stall_cnt != 16'hFFFF)) begin
            cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts beats and read returns,
// and a negedge monitor checks them as the DUT presents them. Honours MEM_ARB_STATS_EN.
module tb_mem_arbiter;
    localparam int MAXB = 4;

    logic        ph1 = 1'b0;
    logic        reset_b = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_rdy;
    logic [7:0]  cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic        dma_gnt;
    logic [7:0]  dma_rdata;
    logic        dma_rvalid;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] cpu_stall_cnt;
`endif

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .DMA_MAX_BURST(MAXB)) dut (
        .ph1(ph1), .reset_b(reset_b),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
        , .cpu_stall_cnt(cpu_stall_cnt)
`endif
    );

    always #5 ph1 = ~ph1;

    // memory macro stand-in
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    always @(posedge ph1) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        bit          dma;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        bit          rdy;
    } beat_t;
    typedef struct {
        bit         dma;
        logic [7:0] data;
    } rd_t;

    beat_t beat_q[$];
    rd_t   rd_q[$];
    int    checks = 0;
    int    errors = 0;

    // reference model: beats of the current DMA run the core waited through, and a pending yield slot
    bit m_yield = 0, m_in_run = 0, m_gc = 0;
    int m_run = 0;
    int m_stalls = 0;

    logic        obs_gnt, obs_rdy, obs_we, obs_en, obs_rvalid;
    logic [15:0] obs_addr;
    logic [7:0]  obs_cpu_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_yield = 0; m_in_run = 0; m_run = 0; m_gc = 0; m_stalls = 0;
        rd_q.delete();
    endtask

    task automatic drive_cycle(input bit cr, input bit cw, input logic [15:0] ca, input logic [7:0] cd,
                               input bit dr, input bit dw, input logic [15:0] da, input logic [7:0] dd);
        bit gd, gc;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        m_gc = 0;
        if (reset_b) begin
            gd = dr && !m_yield;
            gc = cr && !gd;
            if (gd)      beat_q.push_back('{1'b1, dw, da, dd, !cr});
            else if (gc) beat_q.push_back('{1'b0, cw, ca, cd, 1'b1});
            if (gd) begin
                if (dw) ref_mem[da] = dd; else rd_q.push_back('{1'b1, ref_mem[da]});
            end else if (gc) begin
                if (cw) ref_mem[ca] = cd; else rd_q.push_back('{1'b0, ref_mem[ca]});
            end
            if (cr && !gc) m_stalls++;
            if (m_yield) begin
                m_yield = 0; m_run = 0; m_in_run = 0;
            end else if (!gd) begin
                m_run = 0; m_in_run = 0;
            end else if (!m_in_run) begin
                m_in_run = 1; m_run = 1; m_yield = cr && (m_run >= MAXB);
            end else if (cr) begin
                m_run++; m_yield = (m_run >= MAXB);
            end else begin
                m_run = 0;
            end
            m_gc = gc;
        end
        @(negedge ph1);
        obs_gnt = dma_gnt; obs_rdy = cpu_rdy; obs_we = mem_we; obs_en = mem_en;
        obs_addr = mem_addr; obs_cpu_rdata = cpu_rdata; obs_rvalid = dma_rvalid;
        @(posedge ph1); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic reset_pulse();
        reset_b = 1'b0;
        model_reset();
        @(negedge ph1);
        @(posedge ph1); #1;
        reset_b = 1'b1;
    endtask

    // monitor
    bit prev_cpu_rd = 0;
    always @(negedge ph1) begin
        beat_t b;
        rd_t   r;
        if (!reset_b) begin
            chk("rst_mem_en", mem_en, 0);
            chk("rst_dma_gnt", dma_gnt, 0);
            chk("rst_cpu_rdy", cpu_rdy, 0);
            chk("rst_dma_rvalid", dma_rvalid, 0);
            prev_cpu_rd = 0;
        end else begin
            if (prev_cpu_rd || dma_rvalid) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_read_return", 1, 0);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_owner_dma", dma_rvalid, r.dma);
                    chk(r.dma ? "dma_rdata" : "cpu_rdata", r.dma ? dma_rdata : cpu_rdata, r.data);
                end
            end
            if (mem_en) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_dma_gnt", dma_gnt, b.dma);
                    chk("beat_we", mem_we, b.we);
                    chk("beat_addr", mem_addr, b.addr);
                    chk("beat_wdata", mem_wdata, b.wdata);
                    chk("beat_cpu_rdy", cpu_rdy, b.rdy);
                end
            end else begin
                chk("idle_cpu_rdy", cpu_rdy, 1);
                chk("idle_dma_gnt", dma_gnt, 0);
            end
            prev_cpu_rd = mem_en && !mem_we && !dma_gnt;
        end
    end

    initial begin
        bit          cpu_pend;
        bit          cr, cw;
        logic [15:0] ca;
        logic [7:0]  cd;

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'((i * 7) + 3);
            ref_mem[i] = 8'((i * 7) + 3);
        end
        mem[16'h00FF]     = 8'hA5;
        ref_mem[16'h00FF] = 8'hA5;

        // reset held with both requesting
        cpu_req = 1; dma_req = 1; cpu_addr = 16'h0401; dma_addr = 16'h0400;
        repeat (2) @(negedge ph1);
        @(posedge ph1); #1;
        reset_b = 1'b1;
        drive_cycle(1, 0, 16'h0401, 8'h00, 1, 0, 16'h0400, 8'h00);
        chk("first_after_reset_dma_gnt", obs_gnt, 1);
        chk("first_after_reset_cpu_rdy", obs_rdy, 0);
        drive_cycle(1, 0, 16'h0401, 8'h00, 0, 0, 16'h0000, 8'h00);
        idle(2);

        // CPU-only read
        drive_cycle(1, 0, 16'h00FF, 8'h00, 0, 0, '0, '0);
        chk("cpu_rd_en", obs_en, 1);
        chk("cpu_rd_addr", obs_addr, 16'h00FF);
        chk("cpu_rd_rdy", obs_rdy, 1);
        idle(1);
        chk("cpu_rd_data", obs_cpu_rdata, 8'hA5);
        chk("cpu_rd_no_rvalid", obs_rvalid, 0);

        // DMA-only burst, idle core: never yields
        for (int i = 0; i < 10; i++) begin
            drive_cycle(0, 0, '0, '0, 1, 0, 16'h0200 + 16'(i), '0);
            chk("dma_only_gnt", obs_gnt, 1);
        end
        idle(2);

        // contention: DMA x4 then CPU
        reset_pulse();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1, 0, 16'h0600, '0, 1, 0, 16'h0500 + 16'(i), '0);
            chk("contend_dma_gnt", obs_gnt, (i % 5) != 4);
            chk("contend_cpu_rdy", obs_rdy, (i % 5) == 4);
        end
`ifdef MEM_ARB_STATS_EN
        chk("stall_cnt_8", cpu_stall_cnt, 16'd8);
        reset_pulse();
        chk("stall_cnt_cleared", cpu_stall_cnt, 16'd0);
`endif
        idle(2);

        // DMA write then CPU read of the same location
        drive_cycle(1, 0, 16'h1234, '0, 1, 1, 16'h1234, 8'h5A);
        chk("wr_then_rd_dma_first", obs_gnt, 1);
        chk("wr_then_rd_we", obs_we, 1);
        chk("wr_then_rd_stall", obs_rdy, 0);
        drive_cycle(1, 0, 16'h1234, '0, 0, 0, '0, '0);
        chk("wr_then_rd_cpu_beat", obs_gnt, 0);
        chk("wr_then_rd_cpu_rdy", obs_rdy, 1);
        idle(1);
        chk("wr_then_rd_data", obs_cpu_rdata, 8'h5A);
        idle(1);

        // reset pulse during a granted DMA read: its return must vanish
        drive_cycle(0, 0, '0, '0, 1, 0, 16'h0207, '0);
        reset_pulse();
        idle(1);
        chk("no_rvalid_after_reset", obs_rvalid, 0);
        idle(2);

        // randomized traffic, core holds its request until served
        cpu_pend = 0; cr = 0; cw = 0; ca = '0; cd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!cpu_pend) begin
                cr = ($urandom_range(0, 3) != 0);
                cw = 1'($urandom_range(0, 1));
                ca = 16'h0300 + 16'($urandom_range(0, 15));
                cd = 8'($urandom);
            end
            drive_cycle(cr, cw, ca, cd,
                        $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                        16'h0300 + 16'($urandom_range(0, 15)), 8'($urandom));
            cpu_pend = cr && !m_gc;
        end
        idle(3);

        chk("beat_q_drained", beat_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
`ifdef MEM_ARB_STATS_EN
        chk("stall_cnt_final", cpu_stall_cnt, 16'(m_stalls));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
